mul_seq_nbit: RTL and testbench

Parametrised sequential shift-add multiplier for the MIPS ALU datapath, producing a full 2*WIDTH-bit product split into HI/LO halves (mult/multu semantics). It replaces the fixed 4-bit combinational truncating multiplier with a multi-cycle unit that uses a start/busy/done handshake. The ALU control issues an operation and then stalls on `busy`. HI/LO hold the last completed result until the next operation completes.

---
 rtl/mul_pkg.sv | 16 +
 rtl/mul_add_shift_stage.sv | 26 ++
 rtl/mul_seq_nbit.sv | 157 +++++++++++++++
 tb/tb_mul_seq_nbit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
`timescale 1ns/1ps
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mul_state_t;

  // Iteration counter must hold the value WIDTH itself.
  function automatic int unsigned mul_cnt_width(input int unsigned width);
    return $clog2(width + 32'd1);
  endfunction

endpackage

// File: rtl/mul_add_shift_stage.sv
// One shift-add iteration: conditional add of the multiplicand into the upper
// half, then a right shift of the {carry, acc, multiplier} vector.
`timescale 1ns/1ps
module mul_add_shift_stage
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [2*WIDTH-1:0] prod_i,
  output logic [2*WIDTH-1:0] prod_o
);

  logic [WIDTH:0] sum_s;

  // Add with carry-out when the multiplier LSB is set, then drop the consumed LSB.
  always_comb begin
    if (prod_i[0]) begin
      sum_s = {1'b0, prod_i[2*WIDTH-1:WIDTH]} + {1'b0, mcand_i};
    end else begin
      sum_s = {1'b0, prod_i[2*WIDTH-1:WIDTH]};
    end
    prod_o = {sum_s, prod_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/mul_seq_nbit.sv
// Multi-cycle WIDTH x WIDTH -> 2*WIDTH multiplier with start/busy/done handshake.
// Define MUL_SIGNED_EN to honour is_signed (mult); otherwise everything is multu.
`timescale 1ns/1ps
module mul_seq_nbit
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = mul_cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mul_state_t         state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic [WIDTH-1:0]   mag_a_s, mag_b_s;
  logic [2*WIDTH-1:0] stage_s, result_s;

  mul_add_shift_stage #(.WIDTH(WIDTH)) u_stage (
    .mcand_i (mcand_q),
    .prod_i  (prod_q),
    .prod_o  (stage_s)
  );

`ifdef MUL_SIGNED_EN
  logic neg_q, neg_d, neg_s;

  // Sign-magnitude conversion on the way in, conditional negation on the way out.
  always_comb begin
    if (is_signed && a[WIDTH-1]) begin
      mag_a_s = -a;
    end else begin
      mag_a_s = a;
    end
    if (is_signed && b[WIDTH-1]) begin
      mag_b_s = -b;
    end else begin
      mag_b_s = b;
    end
    neg_s = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    if ((state_q == IDLE) && start) begin
      neg_d = neg_s;
    end else begin
      neg_d = neg_q;
    end
    if (neg_q) begin
      result_s = -prod_q;
    end else begin
      result_s = prod_q;
    end
  end

  // Result sign recorded at the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
    end
  end
`else
  logic unused_is_signed_s;
  assign unused_is_signed_s = is_signed;
  assign mag_a_s  = a;
  assign mag_b_s  = b;
  assign result_s = prod_q;
`endif

  // Next-state and datapath update for IDLE -> RUN x WIDTH -> FIX.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = mag_a_s;
          prod_d  = {{WIDTH{1'b0}}, mag_b_s};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          busy_d  = 1'b0;
        end
      end
      RUN: begin
        prod_d = stage_s;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = FIX;
        end else begin
          state_d = RUN;
        end
      end
      FIX: begin
        hi_d    = result_s[2*WIDTH-1:WIDTH];
        lo_d    = result_s[WIDTH-1:0];
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // FSM, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_seq_nbit.sv
// Self-checking bench for mul_seq_nbit at WIDTH=4 and WIDTH=32, either build.
`timescale 1ns/1ps
module tb_mul_seq_nbit;

`ifdef MUL_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        start4 = 1'b0, sgn4 = 1'b0;
  logic [3:0]  a4 = 4'h0, b4 = 4'h0;
  logic        busy4, done4;
  logic [3:0]  hi4, lo4;

  logic        start32 = 1'b0, sgn32 = 1'b0;
  logic [31:0] a32 = 32'h0, b32 = 32'h0;
  logic        busy32, done32;
  logic [31:0] hi32, lo32;

  int n_checks = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  mul_seq_nbit #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .is_signed(sgn4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .hi(hi4), .lo(lo4)
  );

  mul_seq_nbit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .is_signed(sgn32),
    .a(a32), .b(b32), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Exact product of two w-bit operands, reduced to 2w bits.
  function automatic logic [63:0] prod(input int w, input logic [31:0] x,
                                       input logic [31:0] y, input logic s);
    longint sx, sy;
    logic [63:0] p, mask;
    sx = longint'({32'd0, x});
    sy = longint'({32'd0, y});
    if (SGN && s && x[w-1]) sx = sx - (longint'(1) << w);
    if (SGN && s && y[w-1]) sy = sy - (longint'(1) << w);
    p = 64'(sx * sy);
    if (w == 32) mask = '1;
    else mask = (64'd1 << (2 * w)) - 64'd1;
    return p & mask;
  endfunction

  // Reference: countdown of remaining cycles and the pending product.
  int          m4_rem, m32_rem;
  logic        m4_done, m32_done;
  logic [63:0] m4_pend, m32_pend;
  logic [3:0]  m4_hi, m4_lo;
  logic [31:0] m32_hi, m32_lo;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4_rem <= 0; m4_done <= 1'b0; m4_hi <= 4'h0; m4_lo <= 4'h0; m4_pend <= 64'h0;
    end else begin
      m4_done <= 1'b0;
      if (m4_rem == 0) begin
        if (start4) begin
          m4_rem  <= 5;
          m4_pend <= prod(4, {28'h0, a4}, {28'h0, b4}, sgn4);
        end
      end else begin
        m4_rem <= m4_rem - 1;
        if (m4_rem == 1) begin
          m4_done <= 1'b1; m4_hi <= m4_pend[7:4]; m4_lo <= m4_pend[3:0];
        end
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m32_rem <= 0; m32_done <= 1'b0; m32_hi <= 32'h0; m32_lo <= 32'h0; m32_pend <= 64'h0;
    end else begin
      m32_done <= 1'b0;
      if (m32_rem == 0) begin
        if (start32) begin
          m32_rem  <= 33;
          m32_pend <= prod(32, a32, b32, sgn32);
        end
      end else begin
        m32_rem <= m32_rem - 1;
        if (m32_rem == 1) begin
          m32_done <= 1'b1; m32_hi <= m32_pend[63:32]; m32_lo <= m32_pend[31:0];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy4", {63'h0, busy4}, {63'h0, (m4_rem != 0)});
      chk("done4", {63'h0, done4}, {63'h0, m4_done});
      chk("hi4", {60'h0, hi4}, {60'h0, m4_hi});
      chk("lo4", {60'h0, lo4}, {60'h0, m4_lo});
      chk("busy32", {63'h0, busy32}, {63'h0, (m32_rem != 0)});
      chk("done32", {63'h0, done32}, {63'h0, m32_done});
      chk("hi32", {32'h0, hi32}, {32'h0, m32_hi});
      chk("lo32", {32'h0, lo32}, {32'h0, m32_lo});
    end
  end

  // Waits for done4 after an accepting edge; poke>0 pulses a stray start that cycle.
  task automatic wait_done4(input int poke, input bit hold, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    while (!got && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == poke) begin
        start4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
      end else begin
        start4 = hold;
      end
      if (done4) got = 1'b1;
    end
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s,
                     input logic [3:0] eh, input logic [3:0] el, input int poke);
    int lat;
    @(negedge clk);
    a4 = a; b4 = b; sgn4 = s; start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0; a4 = ~a; b4 = ~b; sgn4 = ~s;
    chk("busy4_accept", {63'h0, busy4}, 64'd1);
    wait_done4(poke, 1'b0, lat);
    chk("latency4", 64'(lat), 64'd5);
    chk("hi4_exp", {60'h0, hi4}, {60'h0, eh});
    chk("lo4_exp", {60'h0, lo4}, {60'h0, el});
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [31:0] eh, input logic [31:0] el);
    int lat;
    bit got;
    @(negedge clk);
    a32 = a; b32 = b; sgn32 = s; start32 = 1'b1;
    @(posedge clk);
    #1;
    start32 = 1'b0; a32 = 32'h0; b32 = 32'h0;
    got = 1'b0;
    lat = 0;
    while (!got && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done32) got = 1'b1;
    end
    chk("latency32", 64'(lat), 64'd33);
    chk("hi32_exp", {32'h0, hi32}, {32'h0, eh});
    chk("lo32_exp", {32'h0, lo32}, {32'h0, el});
  endtask

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;
    chk("rst_busy4", {63'h0, busy4}, 64'd0);
    chk("rst_done4", {63'h0, done4}, 64'd0);
    chk("rst_hilo4", {56'h0, hi4, lo4}, 64'd0);
    chk("rst_hilo32", {hi32, lo32}, 64'd0);

    op4(4'h3, 4'h5, 1'b0, 4'h0, 4'hF, 0);
    op4(4'hF, 4'hF, 1'b0, 4'hE, 4'h1, 0);
    if (SGN) begin
      op4(4'hF, 4'hF, 1'b1, 4'h0, 4'h1, 0);
      op4(4'h8, 4'h7, 1'b1, 4'hC, 4'h8, 0);
    end else begin
      op4(4'hF, 4'hF, 1'b1, 4'hE, 4'h1, 0);
      op4(4'h8, 4'h7, 1'b1, 4'h3, 4'h8, 0);
    end
    op4(4'h8, 4'h8, 1'b1, 4'h4, 4'h0, 0);

    if (SGN) op32(32'hFFFFFFFE, 32'h00000003, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA);
    else     op32(32'hFFFFFFFE, 32'h00000003, 1'b1, 32'h00000002, 32'hFFFFFFFA);
    op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001);

    // Stray start in the middle of RUN must not disturb the first result.
    op4(4'h3, 4'h5, 1'b0, 4'h0, 4'hF, 2);

    // start held high through done: second op accepted on the done cycle.
    @(negedge clk);
    a4 = 4'h3; b4 = 4'h5; sgn4 = 1'b0; start4 = 1'b1;
    @(posedge clk);
    wait_done4(0, 1'b1, lat);
    chk("b2b_lat1", 64'(lat), 64'd5);
    chk("b2b_lo1", {60'h0, lo4}, 64'hF);
    a4 = 4'h2; b4 = 4'h6;
    @(posedge clk);
    #1 start4 = 1'b0;
    chk("b2b_busy", {63'h0, busy4}, 64'd1);
    wait_done4(0, 1'b0, lat);
    chk("b2b_lat2", 64'(lat), 64'd5);
    chk("b2b_hilo2", {56'h0, hi4, lo4}, 64'h0C);

    // Reset during RUN clears everything at once and suppresses done.
    @(negedge clk);
    a4 = 4'hF; b4 = 4'hF; sgn4 = 1'b0; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {63'h0, busy4}, 64'd0);
    chk("arst_done", {63'h0, done4}, 64'd0);
    chk("arst_hilo", {56'h0, hi4, lo4}, 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("arst_nodone", {63'h0, done4}, 64'd0);
    end
    op4(4'h7, 4'h6, 1'b0, 4'h2, 4'hA, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
